// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - E->M pipeline stage with valid/ready external memory bus (optional MEM_MISALIGN_TRAP_EN)
//
// Optional build macro: MEM_MISALIGN_TRAP_EN
//   defined   : misaligned H/W/D accesses skip the bus and retire in one cycle with misaligned_m=1
//   undefined : misaligned_m tied 0; access is aligned down to its size and issued normally

module mem_stage_lsu #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_THREADS   = 8,
    parameter int BITS_THREADS  = $clog2(NUM_THREADS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // execute side
    input  logic                      valid_e,
    output logic                      in_ready,
    input  logic                      reg_write_e,
    input  logic [1:0]                result_src_e,
    input  logic                      mem_write_e,
    input  logic [2:0]                funct3_e,
    input  logic [DATA_WIDTH-1:0]     alu_result_e,
    input  logic [DATA_WIDTH-1:0]     write_data_e,
    input  logic [4:0]                rd_e,
    input  logic [ADDRESS_WIDTH-1:0]  pc_plus4_e,
    input  logic [BITS_THREADS-1:0]   tid_e,
    // memory bus
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_req_we,
    output logic [ADDRESS_WIDTH-1:0]  mem_req_addr,
    output logic [DATA_WIDTH/8-1:0]   mem_req_wstrb,
    output logic [DATA_WIDTH-1:0]     mem_req_wdata,
    input  logic                      mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_rsp_rdata,
    // writeback side
    output logic                      valid_m,
    output logic                      reg_write_m,
    output logic [1:0]                result_src_m,
    output logic [DATA_WIDTH-1:0]     alu_result_m,
    output logic [DATA_WIDTH-1:0]     read_data_m,
    output logic [4:0]                rd_m,
    output logic [ADDRESS_WIDTH-1:0]  pc_plus4_m,
    output logic [BITS_THREADS-1:0]   tid_m,
    output logic                      misaligned_m
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t r_state;

    // captured request (held stable through REQ)
    logic                     r_req_we;
    logic [ADDRESS_WIDTH-1:0] r_req_addr;
    logic [STRB_W-1:0]        r_req_wstrb;
    logic [DATA_WIDTH-1:0]    r_req_wdata;
    logic [1:0]               r_size;
    logic                     r_unsigned;
    logic [OFF_W-1:0]         r_offset;

    // writeback fields parked while the access is outstanding
    logic                     r_p_is_load;
    logic                     r_p_reg_write;
    logic [1:0]               r_p_result_src;
    logic [DATA_WIDTH-1:0]    r_p_alu_result;
    logic [4:0]               r_p_rd;
    logic [ADDRESS_WIDTH-1:0] r_p_pc_plus4;
    logic [BITS_THREADS-1:0]  r_p_tid;

    // M-stage registers
    logic                     r_valid_m;
    logic                     r_reg_write_m;
    logic [1:0]               r_result_src_m;
    logic [DATA_WIDTH-1:0]    r_alu_result_m;
    logic [DATA_WIDTH-1:0]    r_read_data_m;
    logic [4:0]               r_rd_m;
    logic [ADDRESS_WIDTH-1:0] r_pc_plus4_m;
    logic [BITS_THREADS-1:0]  r_tid_m;

    logic                     w_is_store;
    logic                     w_is_load;
    logic                     w_is_mem;
    logic                     w_trap;
    logic [ADDRESS_WIDTH-1:0] w_addr;
    logic [ADDRESS_WIDTH-1:0] w_addr_al;
    logic [1:0]               w_size;
    logic                     w_unsigned;
    logic [OFF_W-1:0]         w_off_raw;
    logic [OFF_W-1:0]         w_size_mask;
    logic [OFF_W-1:0]         w_off_al;
    logic [STRB_W-1:0]        w_strb_base;
    logic [STRB_W-1:0]        w_strb;
    logic [DATA_WIDTH-1:0]    w_wdata_rep;
    logic [DATA_WIDTH-1:0]    w_rsp_shift;
    logic [DATA_WIDTH-1:0]    w_load_ext;

    assign w_is_store = mem_write_e;
    assign w_is_load  = (result_src_e == 2'b01) && !mem_write_e;
    assign w_is_mem   = w_is_store || w_is_load;

    generate
        if (ADDRESS_WIDTH <= DATA_WIDTH) begin : g_addr_trunc
            assign w_addr = alu_result_e[ADDRESS_WIDTH-1:0];
        end else begin : g_addr_ext
            assign w_addr = {{(ADDRESS_WIDTH-DATA_WIDTH){1'b0}}, alu_result_e};
        end
    endgenerate

    assign w_addr_al = {w_addr[ADDRESS_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign w_off_raw = w_addr[OFF_W-1:0];

    // funct3 -> access size (0=B,1=H,2=W,3=D) and zero-extend flag; D/WU fold to W on a 32-bit bus
    always_comb begin
        w_size     = 2'd2;
        w_unsigned = 1'b0;
        case (funct3_e)
            3'b000: w_size = 2'd0;
            3'b001: w_size = 2'd1;
            3'b010: w_size = 2'd2;
            3'b011: w_size = (DATA_WIDTH == 64) ? 2'd3 : 2'd2;
            3'b100: begin w_size = 2'd0; w_unsigned = 1'b1; end
            3'b101: begin w_size = 2'd1; w_unsigned = 1'b1; end
            3'b110: begin w_size = 2'd2; w_unsigned = (DATA_WIDTH == 64); end
            default: begin w_size = 2'd2; w_unsigned = 1'b0; end
        endcase
    end

    // lane mask and base strobe for the decoded access size
    always_comb begin
        w_size_mask = '0;
        w_strb_base = STRB_W'(1);
        case (w_size)
            2'd0: begin w_size_mask = '0;        w_strb_base = STRB_W'(1);   end
            2'd1: begin w_size_mask = OFF_W'(1); w_strb_base = STRB_W'(3);   end
            2'd2: begin w_size_mask = OFF_W'(3); w_strb_base = STRB_W'(15);  end
            default: begin w_size_mask = OFF_W'(7); w_strb_base = STRB_W'(255); end
        endcase
    end

    assign w_off_al = w_off_raw & ~w_size_mask;
    assign w_strb   = w_strb_base << w_off_al;

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misaligned_raw;
    logic r_misaligned_m;
    assign w_misaligned_raw = |(w_off_raw & w_size_mask);
    assign w_trap           = w_is_mem && w_misaligned_raw;
    assign misaligned_m     = r_misaligned_m;
`else
    assign w_trap       = 1'b0;
    assign misaligned_m = 1'b0;
`endif

    // replicate store data across every lane so any strobe position sees the right bytes
    always_comb begin
        w_wdata_rep = write_data_e;
        case (w_size)
            2'd0: for (int i = 0; i < STRB_W; i++)          w_wdata_rep[i*8  +: 8]  = write_data_e[7:0];
            2'd1: for (int i = 0; i < STRB_W/2; i++)        w_wdata_rep[i*16 +: 16] = write_data_e[15:0];
            2'd2: for (int i = 0; i < DATA_WIDTH/32; i++)   w_wdata_rep[i*32 +: 32] = write_data_e[31:0];
            default: w_wdata_rep = write_data_e;
        endcase
    end

    assign w_rsp_shift = mem_rsp_rdata >> {r_offset, 3'b000};

    // extract the addressed lane(s) and sign/zero-extend to the full data width
    always_comb begin
        w_load_ext = w_rsp_shift;
        case (r_size)
            2'd0: w_load_ext = r_unsigned ? DATA_WIDTH'(w_rsp_shift[7:0])
                                          : DATA_WIDTH'($signed(w_rsp_shift[7:0]));
            2'd1: w_load_ext = r_unsigned ? DATA_WIDTH'(w_rsp_shift[15:0])
                                          : DATA_WIDTH'($signed(w_rsp_shift[15:0]));
            2'd2: w_load_ext = r_unsigned ? DATA_WIDTH'(w_rsp_shift[31:0])
                                          : DATA_WIDTH'($signed(w_rsp_shift[31:0]));
            default: w_load_ext = w_rsp_shift;
        endcase
    end

    // stage FSM: accept in IDLE, hold request in REQ, wait for one response in RSP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_req_we       <= 1'b0;
            r_req_addr     <= '0;
            r_req_wstrb    <= '0;
            r_req_wdata    <= '0;
            r_size         <= 2'd0;
            r_unsigned     <= 1'b0;
            r_offset       <= '0;
            r_p_is_load    <= 1'b0;
            r_p_reg_write  <= 1'b0;
            r_p_result_src <= 2'b00;
            r_p_alu_result <= '0;
            r_p_rd         <= 5'd0;
            r_p_pc_plus4   <= '0;
            r_p_tid        <= '0;
            r_valid_m      <= 1'b0;
            r_reg_write_m  <= 1'b0;
            r_result_src_m <= 2'b00;
            r_alu_result_m <= '0;
            r_read_data_m  <= '0;
            r_rd_m         <= 5'd0;
            r_pc_plus4_m   <= '0;
            r_tid_m        <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_misaligned_m <= 1'b0;
`endif
        end else begin
            r_valid_m     <= 1'b0;
            r_reg_write_m <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_misaligned_m <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (valid_e) begin
                        if (w_is_mem && !w_trap) begin
                            r_req_we       <= w_is_store;
                            r_req_addr     <= w_addr_al;
                            r_req_wstrb    <= w_is_store ? w_strb : '0;
                            r_req_wdata    <= w_wdata_rep;
                            r_size         <= w_size;
                            r_unsigned     <= w_unsigned;
                            r_offset       <= w_off_al;
                            r_p_is_load    <= w_is_load;
                            r_p_reg_write  <= reg_write_e;
                            r_p_result_src <= result_src_e;
                            r_p_alu_result <= alu_result_e;
                            r_p_rd         <= rd_e;
                            r_p_pc_plus4   <= pc_plus4_e;
                            r_p_tid        <= tid_e;
                            r_state        <= REQ;
                        end else begin
                            // non-memory op (or trapped access) retires next edge
                            r_valid_m      <= 1'b1;
                            r_reg_write_m  <= reg_write_e && !w_trap;
                            r_result_src_m <= result_src_e;
                            r_alu_result_m <= alu_result_e;
                            r_read_data_m  <= '0;
                            r_rd_m         <= rd_e;
                            r_pc_plus4_m   <= pc_plus4_e;
                            r_tid_m        <= tid_e;
`ifdef MEM_MISALIGN_TRAP_EN
                            r_misaligned_m <= w_trap;
`endif
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        r_state <= RSP;
                    end
                end
                RSP: begin
                    if (mem_rsp_valid) begin
                        r_valid_m      <= 1'b1;
                        r_reg_write_m  <= r_p_reg_write;
                        r_result_src_m <= r_p_result_src;
                        r_alu_result_m <= r_p_alu_result;
                        r_read_data_m  <= r_p_is_load ? w_load_ext : '0;
                        r_rd_m         <= r_p_rd;
                        r_pc_plus4_m   <= r_p_pc_plus4;
                        r_tid_m        <= r_p_tid;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready      = (r_state == IDLE);
    assign mem_req_valid = (r_state == REQ);
    assign mem_req_we    = r_req_we;
    assign mem_req_addr  = r_req_addr;
    assign mem_req_wstrb = r_req_wstrb;
    assign mem_req_wdata = r_req_wdata;

    assign valid_m      = r_valid_m;
    assign reg_write_m  = r_reg_write_m;
    assign result_src_m = r_result_src_m;
    assign alu_result_m = r_alu_result_m;
    assign read_data_m  = r_read_data_m;
    assign rd_m         = r_rd_m;
    assign pc_plus4_m   = r_pc_plus4_m;
    assign tid_m        = r_tid_m;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu

module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_e;
    logic        in_ready;
    logic        reg_write_e;
    logic [1:0]  result_src_e;
    logic        mem_write_e;
    logic [2:0]  funct3_e;
    logic [31:0] alu_result_e;
    logic [31:0] write_data_e;
    logic [4:0]  rd_e;
    logic [31:0] pc_plus4_e;
    logic [2:0]  tid_e;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_wstrb;
    logic [31:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        valid_m;
    logic        reg_write_m;
    logic [1:0]  result_src_m;
    logic [31:0] alu_result_m;
    logic [31:0] read_data_m;
    logic [4:0]  rd_m;
    logic [31:0] pc_plus4_m;
    logic [2:0]  tid_m;
    logic        misaligned_m;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_lsu #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .NUM_THREADS(8), .BITS_THREADS(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_e(valid_e), .in_ready(in_ready), .reg_write_e(reg_write_e),
        .result_src_e(result_src_e), .mem_write_e(mem_write_e), .funct3_e(funct3_e),
        .alu_result_e(alu_result_e), .write_data_e(write_data_e), .rd_e(rd_e),
        .pc_plus4_e(pc_plus4_e), .tid_e(tid_e),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .valid_m(valid_m), .reg_write_m(reg_write_m), .result_src_m(result_src_m),
        .alu_result_m(alu_result_m), .read_data_m(read_data_m), .rd_m(rd_m),
        .pc_plus4_m(pc_plus4_m), .tid_m(tid_m), .misaligned_m(misaligned_m)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_e      = 1'b0;
        reg_write_e  = 1'b0;
        result_src_e = 2'b00;
        mem_write_e  = 1'b0;
        funct3_e     = 3'b000;
        alu_result_e = 32'h0;
        write_data_e = 32'h0;
        rd_e         = 5'd0;
        pc_plus4_e   = 32'h0;
        tid_e        = 3'd0;
    endtask

    task automatic issue(input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [2:0] tid, input logic rw);
        valid_e      = 1'b1;
        mem_write_e  = mw;
        result_src_e = rs;
        funct3_e     = f3;
        alu_result_e = a;
        write_data_e = wd;
        rd_e         = rd;
        tid_e        = tid;
        reg_write_e  = rw;
        pc_plus4_e   = 32'h1000_0000 | 32'(rd);
    endtask

    // minimum-latency load: accept, one request cycle with ready, one response cycle
    task automatic run_load(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rdata, input logic [4:0] rd);
        issue(1'b0, 2'b01, f3, a, 32'h0, rd, 3'd1, 1'b1);
        tick();
        idle_inputs();
        check("ld_req_valid", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("ld_no_early_valid", valid_m, 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rdata;
        tick();
        mem_rsp_valid = 1'b0;
        check("ld_valid_m", valid_m, 1);
    endtask

    initial begin
        idle_inputs();
        rst_n         = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'h0;
        tick();
        tick();

        // reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_valid_m", valid_m, 0);
        check("rst_reg_write_m", reg_write_m, 0);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_read_data_m", read_data_m, 0);
        check("rst_rd_m", rd_m, 0);
        check("rst_alu_result_m", alu_result_m, 0);
        check("rst_misaligned_m", misaligned_m, 0);
        rst_n = 1'b1;
        tick();

        // three back-to-back ALU ops
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 2'b00, 3'b000, 32'h100 + 32'(i), 32'h0, 5'(5 + i), 3'(i), 1'b1);
            check("alu_in_ready", in_ready, 1);
            tick();
            check("alu_valid_m", valid_m, 1);
            check("alu_rd_m", rd_m, 5 + i);
            check("alu_tid_m", tid_m, i);
            check("alu_result_m", alu_result_m, 32'h100 + i);
            check("alu_reg_write_m", reg_write_m, 1);
            check("alu_read_data_m", read_data_m, 0);
        end
        idle_inputs();
        tick();
        check("bubble_valid_m", valid_m, 0);
        check("bubble_reg_write_m", reg_write_m, 0);
        check("bubble_rd_hold", rd_m, 7);
        check("bubble_pc4_hold", pc_plus4_m, 32'h1000_0007);

        // LB at 0x1003; response during handshake cycle must be ignored
        issue(1'b0, 2'b01, 3'b000, 32'h1003, 32'h0, 5'd10, 3'd3, 1'b1);
        tick();
        idle_inputs();
        check("lb_req_valid", mem_req_valid, 1);
        check("lb_in_ready", in_ready, 0);
        check("lb_req_we", mem_req_we, 0);
        check("lb_req_addr", mem_req_addr, 32'h1000);
        check("lb_req_wstrb", mem_req_wstrb, 4'b0000);
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h80FF_FF12;
        tick();
        mem_req_ready = 1'b0;
        check("lb_hs_rsp_ignored", valid_m, 0);
        check("lb_req_dropped", mem_req_valid, 0);
        tick();
        mem_rsp_valid = 1'b0;
        check("lb_valid_m", valid_m, 1);
        check("lb_read_data", read_data_m, 32'hFFFF_FF80);
        check("lb_rd_m", rd_m, 10);
        check("lb_tid_m", tid_m, 3);
        check("lb_reg_write_m", reg_write_m, 1);
        check("lb_result_src_m", result_src_m, 2'b01);
        check("lb_alu_result_m", alu_result_m, 32'h1003);
        check("lb_in_ready_back", in_ready, 1);

        run_load(3'b100, 32'h1003, 32'h80FF_FF12, 5'd11);
        check("lbu_read_data", read_data_m, 32'h0000_0080);
        run_load(3'b001, 32'h1002, 32'h8001_7FFF, 5'd12);
        check("lh_read_data", read_data_m, 32'hFFFF_8001);
        run_load(3'b101, 32'h1002, 32'h8001_7FFF, 5'd13);
        check("lhu_read_data", read_data_m, 32'h0000_8001);
        run_load(3'b011, 32'h1000, 32'h8765_4321, 5'd14);
        check("ld32_read_data", read_data_m, 32'h8765_4321);
        check("ld32_rd_m", rd_m, 14);

        // SH 0xBEEF at 0x2002 with ready low for 3 cycles
        issue(1'b1, 2'b00, 3'b001, 32'h2002, 32'h1234_BEEF, 5'd0, 3'd5, 1'b0);
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            check("sh_req_valid", mem_req_valid, 1);
            check("sh_req_we", mem_req_we, 1);
            check("sh_req_addr", mem_req_addr, 32'h2000);
            check("sh_req_wstrb", mem_req_wstrb, 4'b1100);
            check("sh_req_wdata", mem_req_wdata, 32'hBEEF_BEEF);
            tick();
        end
        check("sh_req_still", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("sh_req_done", mem_req_valid, 0);
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        check("sh_valid_m", valid_m, 1);
        check("sh_read_data", read_data_m, 0);
        check("sh_reg_write_m", reg_write_m, 0);
        check("sh_tid_m", tid_m, 5);

        // SB 0xA5 at 0x2001
        issue(1'b1, 2'b00, 3'b000, 32'h2001, 32'h0000_00A5, 5'd0, 3'd2, 1'b0);
        tick();
        idle_inputs();
        check("sb_req_wstrb", mem_req_wstrb, 4'b0010);
        check("sb_req_wdata", mem_req_wdata, 32'hA5A5_A5A5);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        check("sb_valid_m", valid_m, 1);

        // LW at misaligned 0x3001
        issue(1'b0, 2'b01, 3'b010, 32'h3001, 32'h0, 5'd15, 3'd6, 1'b1);
        tick();
        idle_inputs();
`ifdef MEM_MISALIGN_TRAP_EN
        check("mis_valid_m", valid_m, 1);
        check("mis_flag", misaligned_m, 1);
        check("mis_reg_write_m", reg_write_m, 0);
        check("mis_read_data", read_data_m, 0);
        check("mis_no_req", mem_req_valid, 0);
        check("mis_in_ready", in_ready, 1);
`else
        check("mis_req_valid", mem_req_valid, 1);
        check("mis_req_addr", mem_req_addr, 32'h3000);
        check("mis_flag_tied", misaligned_m, 0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h8765_4321;
        tick();
        mem_rsp_valid = 1'b0;
        check("mis_valid_m", valid_m, 1);
        check("mis_read_data", read_data_m, 32'h8765_4321);
        check("mis_flag_after", misaligned_m, 0);
`endif

        // reset while REQ: request drops asynchronously
        issue(1'b0, 2'b01, 3'b010, 32'h4000, 32'h0, 5'd16, 3'd7, 1'b1);
        tick();
        idle_inputs();
        check("rreq_req_valid", mem_req_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rreq_req_drop", mem_req_valid, 0);
        check("rreq_in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();

        // reset while RSP: stale response after release is ignored
        issue(1'b0, 2'b01, 3'b010, 32'h4000, 32'h0, 5'd17, 3'd7, 1'b1);
        tick();
        idle_inputs();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rrsp_req_valid", mem_req_valid, 0);
        check("rrsp_valid_m", valid_m, 0);
        check("rrsp_in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hFFFF_FFFF;
        tick();
        mem_rsp_valid = 1'b0;
        check("stale_rsp_valid_m", valid_m, 0);
        check("stale_rsp_rd_m", rd_m, 0);

        // reset right after a retire clears valid_m immediately
        issue(1'b0, 2'b00, 3'b000, 32'h55, 32'h0, 5'd20, 3'd4, 1'b1);
        tick();
        idle_inputs();
        check("rv_valid_m_pre", valid_m, 1);
        rst_n = 1'b0;
        #1;
        check("rv_valid_m_drop", valid_m, 0);
        check("rv_rd_m_clear", rd_m, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
